// File: rtl/video_timing_scaler.sv
// Purpose : parametrised raster timing generator with an integer-upscaled frame-buffer window.
// Latency : fb_addr/fb_rd on the raw timeline; all video outputs RD_LAT+1 clocks after raw.
// Backpressure: none, free-running pixel clock; enable is honoured only at frame boundaries.
// Optional: define VIDEO_TIMING_SCALER_TESTPAT_EN to add i_tp_sel (colour-bar test pattern).
module video_timing_scaler #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CNT_W    = 12,
  parameter int SRC_W    = 640,
  parameter int SRC_H    = 480,
  parameter int SCALE    = 2,
  parameter int WIN_X    = 320,
  parameter int WIN_Y    = 60,
  parameter int ADDR_W   = 19,
  parameter int PIX_W    = 12,
  parameter int RD_LAT   = 1,
  parameter logic [PIX_W-1:0] BORDER = 12'h000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
  input  logic              i_tp_sel,
`endif
  input  logic [PIX_W-1:0]  i_pix_in,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic              o_fb_rd,
  output logic [CNT_W-1:0]  o_hcnt,
  output logic [CNT_W-1:0]  o_vcnt,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_blank_n,
  output logic              o_sync_n,
  output logic [PIX_W-1:0]  o_pix_out,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DLY     = RD_LAT + 1;
  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] WX_BEG  = CNT_W'(WIN_X);
  localparam logic [CNT_W-1:0] WX_END  = CNT_W'(WIN_X + SRC_W * SCALE);
  localparam logic [CNT_W-1:0] WX_LAST = CNT_W'(WIN_X + SRC_W * SCALE - 1);
  localparam logic [CNT_W-1:0] WY_BEG  = CNT_W'(WIN_Y);
  localparam logic [CNT_W-1:0] WY_END  = CNT_W'(WIN_Y + SRC_H * SCALE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Parameter sanity: a bad configuration stops elaboration with a message.
  if (SCALE < 1) begin : g_err_scale
    $error("video_timing_scaler: SCALE must be >= 1");
  end
  if (WIN_X + SRC_W * SCALE > H_ACTIVE || WIN_Y + SRC_H * SCALE > V_ACTIVE) begin : g_err_win
    $error("video_timing_scaler: scaled window does not fit inside the active area");
  end
  if (RD_LAT < 0 || RD_LAT > 4) begin : g_err_lat
    $error("video_timing_scaler: RD_LAT must be 0..4");
  end
  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_err_cnt
    $error("video_timing_scaler: CNT_W too narrow for the raster");
  end
  if (SRC_W * SRC_H > (1 << ADDR_W)) begin : g_err_addr
    $error("video_timing_scaler: ADDR_W too narrow for the source image");
  end

  typedef enum logic {S_PARKED, S_RUN} state_t;

  // Everything that travels with the pixel from the raw timeline to the pins.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic             blank_n;
    logic             sync_n;
    logic             fs;
    logic             win;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
    logic             tp;
    logic [PIX_W-1:0] tp_pix;
`endif
  } pipe_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_rh;
  logic [CNT_W-1:0]  r_rv;
  logic [SUB_W-1:0]  r_xsub;
  logic [SUB_W-1:0]  r_ysub;
  logic [ADDR_W-1:0] r_src_x;
  logic [ADDR_W-1:0] r_line_base;
  pipe_t             r_pipe [1:DLY];
  logic [PIX_W-1:0]  r_pix;

  logic  w_run;
  logic  w_last_pix;
  logic  w_hs_act;
  logic  w_vs_act;
  logic  w_win;
  pipe_t w_raw;
  pipe_t w_idle;
  pipe_t w_pre;

  assign w_run      = (r_state == S_RUN);
  assign w_last_pix = (r_rh == H_LAST) && (r_rv == V_LAST);
  assign w_hs_act   = (r_rh >= HS_BEG) && (r_rh < HS_END);
  assign w_vs_act   = (r_rv >= VS_BEG) && (r_rv < VS_END);
  assign w_win      = w_run && (r_rh >= WX_BEG) && (r_rh < WX_END)
                            && (r_rv >= WY_BEG) && (r_rv < WY_END);

  // Run/park control and raw H/V counters; a stopped frame always runs to its last pixel.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_PARKED;
      r_rh    <= '0;
      r_rv    <= '0;
    end else begin
      case (r_state)
        S_PARKED: begin
          r_rh <= '0;
          r_rv <= '0;
          if (i_enable) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_last_pix) begin
            r_rh <= '0;
            r_rv <= '0;
            if (!i_enable) r_state <= S_PARKED;
          end else if (r_rh == H_LAST) begin
            r_rh <= '0;
            r_rv <= r_rv + 1'b1;
          end else begin
            r_rh <= r_rh + 1'b1;
          end
        end
        default: r_state <= S_PARKED;
      endcase
    end
  end

  // Incremental source addressing: x repeats each source pixel SCALE times, the line
  // base advances one source row every SCALE window lines, and both restart each frame.
  always_ff @(posedge i_clk) begin
    if (i_reset || !w_run) begin
      r_xsub      <= '0;
      r_ysub      <= '0;
      r_src_x     <= '0;
      r_line_base <= '0;
    end else begin
      if (w_win) begin
        if (r_xsub == SUB_LAST) begin
          r_xsub  <= '0;
          r_src_x <= r_src_x + 1'b1;
        end else begin
          r_xsub <= r_xsub + 1'b1;
        end
      end else begin
        r_xsub  <= '0;
        r_src_x <= '0;
      end
      if (w_last_pix) begin
        r_ysub      <= '0;
        r_line_base <= '0;
      end else if (w_win && (r_rh == WX_LAST)) begin
        if (r_ysub == SUB_LAST) begin
          r_ysub      <= '0;
          r_line_base <= r_line_base + SRC_W_A;
        end else begin
          r_ysub <= r_ysub + 1'b1;
        end
      end
    end
  end

`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
  logic [ADDR_W+2:0] w_sx8;
  logic [2:0]        w_bar;
  assign w_sx8 = {r_src_x, 3'b000};
  // Bar index = src_x*8/SRC_W, found by comparing against the seven bar edges.
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (w_sx8 >= (ADDR_W+3)'(k * SRC_W)) w_bar = 3'(k);
    end
  end
`endif

  // Idle (parked/reset) values of the travelling signals.
  always_comb begin
    w_idle        = '0;
    w_idle.hs     = ~HS_ON;
    w_idle.vs     = ~VS_ON;
    w_idle.sync_n = 1'b1;
  end

  // Raw-timeline video flags; parked state produces the idle values.
  always_comb begin
    w_raw         = '0;
    w_raw.hs      = (w_run && w_hs_act) ? HS_ON : ~HS_ON;
    w_raw.vs      = (w_run && w_vs_act) ? VS_ON : ~VS_ON;
    w_raw.de      = w_run && (r_rh < H_ACT) && (r_rv < V_ACT);
    w_raw.blank_n = w_raw.de;
    w_raw.sync_n  = ~(w_run && (w_hs_act || w_vs_act));
    w_raw.fs      = w_run && (r_rh == '0) && (r_rv == '0);
    w_raw.win     = w_win;
    w_raw.hcnt    = r_rh;
    w_raw.vcnt    = r_rv;
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
    w_raw.tp      = i_tp_sel;
    w_raw.tp_pix  = PIX_W'({{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}});
`endif
  end

  // Alignment shift pipeline, cleared by reset so no stale frame leaks out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 1; i <= DLY; i++) r_pipe[i] <= w_idle;
    end else begin
      r_pipe[1] <= w_raw;
      for (int i = 2; i <= DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // The stage that is in step with pix_in feeds the output pixel register.
  if (RD_LAT == 0) begin : g_pre_raw
    assign w_pre = w_raw;
  end else begin : g_pre_pipe
    assign w_pre = r_pipe[RD_LAT];
  end

  // Output pixel: black in blanking, frame data in the window, border colour elsewhere.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pix <= '0;
    end else if (!w_pre.de) begin
      r_pix <= '0;
    end else if (w_pre.win) begin
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
      r_pix <= w_pre.tp ? w_pre.tp_pix : i_pix_in;
`else
      r_pix <= i_pix_in;
`endif
    end else begin
      r_pix <= BORDER;
    end
  end

`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
  assign o_fb_rd = w_win & ~i_tp_sel;
`else
  assign o_fb_rd = w_win;
`endif
  assign o_fb_addr     = w_win ? (r_line_base + r_src_x) : '0;
  assign o_hcnt        = r_pipe[DLY].hcnt;
  assign o_vcnt        = r_pipe[DLY].vcnt;
  assign o_hsync       = r_pipe[DLY].hs;
  assign o_vsync       = r_pipe[DLY].vs;
  assign o_de          = r_pipe[DLY].de;
  assign o_blank_n     = r_pipe[DLY].blank_n;
  assign o_sync_n      = r_pipe[DLY].sync_n;
  assign o_frame_start = r_pipe[DLY].fs;
  assign o_pix_out     = r_pix;

endmodule

// File: tb/tb_video_timing_scaler.sv
// Bench for video_timing_scaler: tiny 14x7 raster, inverted polarity, RD_LAT sweep 0..4,
// enable drop, mid-frame reset, and a 52x26 raster run for two frames.
// Free-running clock; expected values come from a closed-form raster model.
module tb_video_timing_scaler;

  localparam logic [11:0] BRD = 12'h0F0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // ---------------- tiny raster, RD_LAT=1, positive sync ----------------
  logic [18:0] t_addr, t_dly;
  logic [11:0] t_hc, t_vc, t_pix, t_pin;
  logic        t_rd, t_hs, t_vs, t_de, t_bn, t_sn, t_fs;
  always @(posedge clk) t_dly <= t_addr;
  assign t_pin = t_dly[11:0];

  video_timing_scaler #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1), .VS_POL(1), .CNT_W(12), .SRC_W(2), .SRC_H(2), .SCALE(2),
    .WIN_X(2), .WIN_Y(0), .ADDR_W(19), .PIX_W(12), .RD_LAT(1), .BORDER(BRD)) u_tiny (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
    .i_tp_sel(1'b0),
`endif
    .i_pix_in(t_pin), .o_fb_addr(t_addr), .o_fb_rd(t_rd), .o_hcnt(t_hc), .o_vcnt(t_vc),
    .o_hsync(t_hs), .o_vsync(t_vs), .o_de(t_de), .o_blank_n(t_bn), .o_sync_n(t_sn),
    .o_pix_out(t_pix), .o_frame_start(t_fs));

  // ---------------- tiny raster, negative sync ----------------
  logic [18:0] p_addr;
  logic [11:0] p_hc, p_vc, p_pix;
  logic        p_rd, p_hs, p_vs, p_de, p_bn, p_sn, p_fs;

  video_timing_scaler #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(0), .VS_POL(0), .CNT_W(12), .SRC_W(2), .SRC_H(2), .SCALE(2),
    .WIN_X(2), .WIN_Y(0), .ADDR_W(19), .PIX_W(12), .RD_LAT(1), .BORDER(BRD)) u_pol (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
    .i_tp_sel(1'b0),
`endif
    .i_pix_in(12'h000), .o_fb_addr(p_addr), .o_fb_rd(p_rd), .o_hcnt(p_hc), .o_vcnt(p_vc),
    .o_hsync(p_hs), .o_vsync(p_vs), .o_de(p_de), .o_blank_n(p_bn), .o_sync_n(p_sn),
    .o_pix_out(p_pix), .o_frame_start(p_fs));

  // ---------------- RD_LAT sweep, RAM model returns address as data ----------------
  logic [11:0] l_pix [0:4];

  for (genvar g = 0; g < 5; g++) begin : g_lat
    logic [18:0] addr;
    logic [18:0] dly [0:4];
    logic [11:0] hc, vc, pix, pin;
    logic        rd, hs, vs, de, bn, sn, fs;
    always @(posedge clk) begin
      dly[0] <= addr;
      for (int i = 1; i < 5; i++) dly[i] <= dly[i-1];
    end
    if (g == 0) begin : g_comb
      assign pin = addr[11:0];
    end else begin : g_reg
      assign pin = dly[g-1][11:0];
    end
    assign l_pix[g] = pix;
    video_timing_scaler #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1), .VS_POL(1), .CNT_W(12), .SRC_W(2), .SRC_H(2), .SCALE(2),
      .WIN_X(2), .WIN_Y(0), .ADDR_W(19), .PIX_W(12), .RD_LAT(g), .BORDER(BRD)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
      .i_tp_sel(1'b0),
`endif
      .i_pix_in(pin), .o_fb_addr(addr), .o_fb_rd(rd), .o_hcnt(hc), .o_vcnt(vc),
      .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_blank_n(bn), .o_sync_n(sn),
      .o_pix_out(pix), .o_frame_start(fs));
  end

  // ---------------- medium raster 52x26, SRC 8x6, SCALE 3, RD_LAT 2 ----------------
  logic [18:0] m_addr;
  logic [11:0] m_hc, m_vc, m_pix;
  logic        m_rd, m_hs, m_vs, m_de, m_bn, m_sn, m_fs;

  video_timing_scaler #(.H_ACTIVE(40), .H_FP(4), .H_SYNC(4), .H_BP(4), .V_ACTIVE(20), .V_FP(2),
    .V_SYNC(2), .V_BP(2), .HS_POL(1), .VS_POL(1), .CNT_W(12), .SRC_W(8), .SRC_H(6), .SCALE(3),
    .WIN_X(4), .WIN_Y(1), .ADDR_W(19), .PIX_W(12), .RD_LAT(2), .BORDER(BRD)) u_med (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef VIDEO_TIMING_SCALER_TESTPAT_EN
    .i_tp_sel(1'b0),
`endif
    .i_pix_in(12'h000), .o_fb_addr(m_addr), .o_fb_rd(m_rd), .o_hcnt(m_hc), .o_vcnt(m_vc),
    .o_hsync(m_hs), .o_vsync(m_vs), .o_de(m_de), .o_blank_n(m_bn), .o_sync_n(m_sn),
    .o_pix_out(m_pix), .o_frame_start(m_fs));

  // ---------------- tiny raster model ----------------
  typedef struct packed {
    logic hs, vs, de, bn, sn, fs, win;
    logic [11:0] h, v;
    logic [18:0] addr;
    logic [11:0] pix;
  } exp_t;

  // n = clocks since the first running cycle; n < 0 means parked/reset values.
  function automatic exp_t tiny_model(int n, bit pol);
    exp_t e;
    int h, v;
    bit hsa, vsa;
    e = '0;
    e.hs = !pol; e.vs = !pol; e.sn = 1'b1;
    if (n >= 0) begin
      h = n % 14;
      v = (n / 14) % 7;
      hsa = (h >= 10) && (h <= 11);
      vsa = (v == 5);
      e.de = (h < 8) && (v < 4);
      e.bn = e.de;
      e.hs = hsa ? pol : !pol;
      e.vs = vsa ? pol : !pol;
      e.sn = !(hsa || vsa);
      e.fs = (h == 0) && (v == 0);
      e.win = (h >= 2) && (h < 6) && (v < 4);
      e.h = 12'(h);
      e.v = 12'(v);
      e.addr = e.win ? 19'((v / 2) * 2 + (h - 2) / 2) : 19'd0;
      e.pix = !e.de ? 12'h000 : (e.win ? e.addr[11:0] : BRD);
    end
    return e;
  endfunction

  // Reset then raise enable; returns just after the edge that samples enable.
  task automatic start_run;
    @(negedge clk); rst = 1'b1; en = 1'b0;
    @(negedge clk); rst = 1'b0; en = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset;
    exp_t e;
    rst = 1'b1; en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = tiny_model(-1, 1'b1);
    checks++;
    if ({t_hs, t_vs, t_de, t_bn, t_sn, t_fs, t_rd} !== {e.hs, e.vs, e.de, e.bn, e.sn, e.fs, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", {t_hs, t_vs, t_de, t_bn, t_sn, t_fs, t_rd},
                         {e.hs, e.vs, e.de, e.bn, e.sn, e.fs, 1'b0});
    end
    checks++;
    if ({t_hc, t_vc, t_pix, t_addr} !== {12'd0, 12'd0, 12'd0, 19'd0}) begin
      errors++; $display("FAIL reset_data got hc=%0d vc=%0d pix=%h addr=%0d exp all 0", t_hc, t_vc, t_pix, t_addr);
    end
    checks++;
    if ({p_hs, p_vs, p_sn} !== 3'b111) begin
      errors++; $display("FAIL reset_pol_idle got %b exp 111", {p_hs, p_vs, p_sn});
    end
  endtask

  task automatic test_tiny_raster;
    exp_t e, r;
    int fs_n[$];
    start_run();
    for (int n = 0; n <= 102; n++) begin
      @(negedge clk);
      e = tiny_model(n - 2, 1'b1);
      r = tiny_model(n, 1'b1);
      if (t_fs === 1'b1) fs_n.push_back(n);
      checks++;
      if ({t_hs, t_vs, t_de, t_bn, t_sn, t_fs} !== {e.hs, e.vs, e.de, e.bn, e.sn, e.fs}) begin
        errors++; $display("FAIL tiny_ctrl n=%0d got %b exp %b", n, {t_hs, t_vs, t_de, t_bn, t_sn, t_fs},
                           {e.hs, e.vs, e.de, e.bn, e.sn, e.fs});
      end
      checks++;
      if ({t_hc, t_vc} !== {e.h, e.v}) begin
        errors++; $display("FAIL tiny_cnt n=%0d got %0d,%0d exp %0d,%0d", n, t_hc, t_vc, e.h, e.v);
      end
      checks++;
      if (t_pix !== e.pix) begin
        errors++; $display("FAIL tiny_pix n=%0d got %h exp %h", n, t_pix, e.pix);
      end
      checks++;
      if (t_rd !== r.win) begin
        errors++; $display("FAIL tiny_fb_rd n=%0d got %b exp %b", n, t_rd, r.win);
      end
      if (r.win) begin
        checks++;
        if (t_addr !== r.addr) begin
          errors++; $display("FAIL tiny_fb_addr n=%0d got %0d exp %0d", n, t_addr, r.addr);
        end
      end
    end
    checks++;
    if (fs_n.size() != 2 || fs_n[0] != 2 || fs_n[1] != 100) begin
      errors++; $display("FAIL tiny_frame_period got %0d pulses first=%0d second=%0d exp 2 at 2 and 100",
                         fs_n.size(), (fs_n.size() > 0) ? fs_n[0] : -1, (fs_n.size() > 1) ? fs_n[1] : -1);
    end
  endtask

  task automatic test_polarity;
    exp_t e;
    start_run();
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      e = tiny_model(n - 2, 1'b0);
      checks++;
      if ({p_hs, p_vs, p_sn} !== {e.hs, e.vs, e.sn}) begin
        errors++; $display("FAIL pol_sync n=%0d got %b exp %b", n, {p_hs, p_vs, p_sn}, {e.hs, e.vs, e.sn});
      end
    end
  endtask

  task automatic test_latency_sweep;
    exp_t e;
    start_run();
    for (int n = 0; n <= 106; n++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
        e = tiny_model(n - (g + 1), 1'b1);
        checks++;
        if (l_pix[g] !== e.pix) begin
          errors++; $display("FAIL lat%0d_pix n=%0d got %h exp %h", g, n, l_pix[g], e.pix);
        end
      end
    end
  endtask

  task automatic test_enable_drop;
    exp_t e, r;
    start_run();
    for (int n = 0; n <= 120; n++) begin
      @(negedge clk);
      e = (n - 2 >= 98) ? tiny_model(-1, 1'b1) : tiny_model(n - 2, 1'b1);
      r = (n >= 98) ? tiny_model(-1, 1'b1) : tiny_model(n, 1'b1);
      checks++;
      if ({t_hs, t_vs, t_de, t_bn, t_sn, t_fs, t_hc, t_vc, t_pix} !==
          {e.hs, e.vs, e.de, e.bn, e.sn, e.fs, e.h, e.v, e.pix}) begin
        errors++; $display("FAIL drop_out n=%0d got hc=%0d vc=%0d de=%b fs=%b pix=%h exp hc=%0d vc=%0d de=%b fs=%b pix=%h",
                           n, t_hc, t_vc, t_de, t_fs, t_pix, e.h, e.v, e.de, e.fs, e.pix);
      end
      checks++;
      if (t_rd !== r.win) begin
        errors++; $display("FAIL drop_fb_rd n=%0d got %b exp %b", n, t_rd, r.win);
      end
      if (n == 20) en = 1'b0;
    end
    en = 1'b1;
    @(posedge clk);
    for (int m = 0; m <= 4; m++) begin
      @(negedge clk);
      checks++;
      if (t_fs !== (m == 2)) begin
        errors++; $display("FAIL restart_fs m=%0d got %b exp %b", m, t_fs, (m == 2));
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e, r;
    start_run();
    for (int n = 0; n <= 33; n++) @(negedge clk);
    checks++;
    if ({t_rd, t_addr} !== {1'b1, 19'd3}) begin
      errors++; $display("FAIL midrst_pre got rd=%b addr=%0d exp rd=1 addr=3", t_rd, t_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    e = tiny_model(-1, 1'b1);
    checks++;
    if ({t_hs, t_vs, t_de, t_bn, t_sn, t_fs, t_rd} !== {e.hs, e.vs, e.de, e.bn, e.sn, e.fs, 1'b0}) begin
      errors++; $display("FAIL midrst_ctrl got %b exp %b", {t_hs, t_vs, t_de, t_bn, t_sn, t_fs, t_rd},
                         {e.hs, e.vs, e.de, e.bn, e.sn, e.fs, 1'b0});
    end
    checks++;
    if ({t_hc, t_vc, t_pix, t_addr} !== {12'd0, 12'd0, 12'd0, 19'd0}) begin
      errors++; $display("FAIL midrst_data got hc=%0d vc=%0d pix=%h addr=%0d exp all 0", t_hc, t_vc, t_pix, t_addr);
    end
    rst = 1'b0;
    @(posedge clk);
    for (int m = 0; m <= 5; m++) begin
      @(negedge clk);
      e = tiny_model(m - 2, 1'b1);
      r = tiny_model(m, 1'b1);
      checks++;
      if ({t_fs, t_de, t_hc, t_vc, t_rd} !== {e.fs, e.de, e.h, e.v, r.win}) begin
        errors++; $display("FAIL midrst_restart m=%0d got fs=%b de=%b hc=%0d vc=%0d rd=%b exp fs=%b de=%b hc=%0d vc=%0d rd=%b",
                           m, t_fs, t_de, t_hc, t_vc, t_rd, e.fs, e.de, e.h, e.v, r.win);
      end
    end
  endtask

  task automatic test_medium_frames;
    int fs_n[$];
    int de_cnt = 0;
    int rd_cnt = 0;
    logic [18:0] peak = '0;
    start_run();
    for (int n = 0; n <= 2 * 1352 + 10; n++) begin
      @(negedge clk);
      if (m_fs === 1'b1) fs_n.push_back(n);
      if (n >= 3 && n < 3 + 1352 && m_de === 1'b1) de_cnt++;
      if (n < 1352 && m_rd === 1'b1) rd_cnt++;
      if (m_rd === 1'b1 && m_addr > peak) peak = m_addr;
    end
    checks++;
    if (fs_n.size() < 2) begin
      errors++; $display("FAIL med_frame_start got %0d pulses exp at least 2 within budget", fs_n.size());
    end else if (fs_n[0] != 3 || fs_n[1] - fs_n[0] != 1352) begin
      errors++; $display("FAIL med_frame_start got first=%0d spacing=%0d exp first=3 spacing=1352",
                         fs_n[0], fs_n[1] - fs_n[0]);
    end
    checks++;
    if (peak !== 19'd47) begin
      errors++; $display("FAIL med_peak_addr got %0d exp 47", peak);
    end
    checks++;
    if (de_cnt != 800) begin
      errors++; $display("FAIL med_de_count got %0d exp 800", de_cnt);
    end
    checks++;
    if (rd_cnt != 432) begin
      errors++; $display("FAIL med_fb_rd_count got %0d exp 432", rd_cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tiny_raster();
    test_polarity();
    test_latency_sweep();
    test_enable_drop();
    test_reset_mid();
    test_medium_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
